envelope_vca: RTL and testbench

- Envelope-controlled amplifier that sits directly downstream of the decay envelope generator and upstream of the I2S transmitter.
- Multiplies each signed 16-bit audio sample by the unsigned 16-bit envelope value, with either a linear or a squared gain curve.
- Uses a serial shift-add multiplier instead of a DSP tile, so the SB_MAC16 blocks stay free for oscillators and filters.
- One result is produced per accepted sample strobe.

---
 rtl/envelope_vca.sv | 121 ++++++++++++
 tb/tb_envelope_vca.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// Envelope VCA: scales a signed 16-bit sample by a clamped Q1.15 envelope, with an optional squared gain curve.
// Serial shift-add multiply: 17 clocks (linear) or 33 clocks (squared) from strobe to out_valid; strobes while busy are dropped and flagged.
module envelope_vca #(
  parameter int SHIFT     = 15,
  parameter bit SQUARE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  input  logic [15:0]        envelope,
  input  logic               curve_sel,
  output logic signed [15:0] sample_out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int ACC_W = 33;

  typedef enum logic [1:0] {IDLE, SQUARE, SCALE, DONE} state_t;

  state_t                   state_q;
  logic [3:0]               cnt_q;
  logic signed [15:0]       sample_q;
  logic [15:0]              mplier_q;
  logic signed [ACC_W-1:0]  mcand_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [15:0]       sample_out_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic                     overrun_q;

  logic [15:0]              env_clamp;
  logic signed [ACC_W-1:0]  addend;
  logic signed [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]         sq_shift;
  logic [15:0]              gain_sq;

  // Anything at or above unity collapses to exactly 0x8000.
  assign env_clamp = envelope[15] ? 16'h8000 : envelope;
  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign acc_d     = acc_q + addend;
  assign sq_shift  = acc_d >> SHIFT;
  assign gain_sq   = (sq_shift > ACC_W'(32'h8000)) ? 16'h8000 : sq_shift[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sample_q     <= '0;
      mplier_q     <= '0;
      mcand_q      <= '0;
      acc_q        <= '0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (sample_valid && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            sample_q <= sample_in;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            mplier_q <= env_clamp;
            if (curve_sel && SQUARE_EN) begin
              mcand_q <= ACC_W'(env_clamp);
              state_q <= SQUARE;
            end else begin
              mcand_q <= ACC_W'(sample_in);
              state_q <= SCALE;
            end
          end
        end
        SQUARE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // Squared gain becomes the multiplier for the sample pass.
            acc_q    <= '0;
            mcand_q  <= ACC_W'(sample_q);
            mplier_q <= gain_sq;
            state_q  <= SCALE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q <<< 1;
            mplier_q <= mplier_q >> 1;
          end
        end
        SCALE: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q <<< 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Bit-select of the two's-complement product is a floor shift.
          sample_out_q <= acc_q[SHIFT +: 16];
          out_valid_q  <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Scoreboard bench for envelope_vca: a driver predicts results and timing from arithmetic, a monitor compares.
module tb_envelope_vca;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic [15:0]        envelope;
  logic               curve_sel;
  logic signed [15:0] sample_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  always #5 clk = ~clk;

  envelope_vca dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .envelope     (envelope),
    .curve_sel    (curve_sel),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  typedef struct {
    logic signed [15:0] val;
    int                 at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   blo      = 0;
  int   bhi      = 0;
  int   free_at  = 0;
  int   ovr_from = 2147483647;
  int   tgt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
    end
  endfunction

  // Reference: floor(sample * gain / 32768), gain = clamp(env) or clamp(env)^2/32768.
  function automatic logic signed [15:0] ref_out(input logic signed [15:0] s,
                                                 input logic [15:0] e, input logic cv);
    longint c, g, p;
    c = (e >= 16'h8000) ? 64'sd32768 : longint'(e);
    if (cv) begin
      g = (c * c) / 32768;
      if (g > 32768) g = 32768;
    end else begin
      g = c;
    end
    p = longint'(s) * g;
    return 16'(p >>> 15);
  endfunction

  task automatic strobe(input logic signed [15:0] s, input logic [15:0] e, input logic cv);
    int c0, lat;
    @(negedge clk);
    sample_in    = s;
    envelope     = e;
    curve_sel    = cv;
    sample_valid = 1'b1;
    c0  = cyc + 1;
    lat = cv ? 33 : 17;
    if (c0 >= free_at) begin
      sbq.push_back('{val: ref_out(s, e, cv), at: c0 + lat});
      blo     = c0;
      bhi     = c0 + lat;
      free_at = c0 + lat + 1;
    end else if (ovr_from > c0) begin
      ovr_from = c0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_valid = 1'b0;
      sample_in    = 16'($urandom);
      envelope     = 16'($urandom);
      curve_sel    = 1'($urandom);
    end
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("rst_sample_out", longint'(sample_out), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_overrun", longint'(overrun), 0);
    sbq.delete();
    bhi      = 0;
    free_at  = 0;
    ovr_from = 2147483647;
    repeat (hold) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("busy", longint'(busy), longint'(cyc >= blo && cyc < bhi));
      check("overrun", longint'(overrun), longint'(cyc >= ovr_from));
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", longint'(out_valid), 0);
        end else begin
          mon_e = sbq.pop_front();
          check("sample_out", longint'(sample_out), longint'(mon_e.val));
          check("out_valid_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    envelope     = '0;
    curve_sel    = 1'b0;
    #13;
    check("init_sample_out", longint'(sample_out), 0);
    check("init_out_valid", longint'(out_valid), 0);
    check("init_busy", longint'(busy), 0);
    check("init_overrun", longint'(overrun), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    idle(3);

    // Directed gain cases: linear, decay peak, floor, squared, clamp, zero, unity.
    strobe(16'sh4000, 16'h4000, 1'b0);   idle(20);
    strobe(16'sh8000, 16'h7FFC, 1'b0);   idle(20);
    strobe(16'shFFFF, 16'h0001, 1'b0);   idle(20);
    strobe(16'sh7FFF, 16'h4000, 1'b1);   idle(36);
    strobe(-16'sd1234, 16'hFFFF, 1'b1);  idle(36);
    strobe(16'sd1234, 16'h0000, 1'b0);   idle(20);
    strobe(16'sh8000, 16'h8000, 1'b0);   idle(20);
    strobe(16'sh7FFF, 16'hFFFF, 1'b0);   idle(20);

    // Overrun 5 clocks in, then a strobe in the out_valid cycle.
    strobe(16'sh1111, 16'h6000, 1'b0);
    tgt = bhi;
    idle(4);
    strobe(16'sh7777, 16'h7000, 1'b0);
    while (cyc < tgt - 1) idle(1);
    strobe(16'sh2345, 16'h3000, 1'b0);
    idle(20);

    // Envelope and curve change mid-operation must not matter.
    strobe(16'sh4000, 16'h4000, 1'b0);
    idle(8);
    @(negedge clk);
    sample_valid = 1'b0;
    envelope     = 16'h0000;
    curve_sel    = 1'b1;
    idle(12);

    // Reset in the middle of SCALE.
    strobe(16'sh7000, 16'h5000, 1'b0);
    idle(10);
    do_reset(3);
    idle(40);
    strobe(16'sh7000, 16'h5000, 1'b0);
    idle(20);

    for (int i = 0; i < 80; i++) begin
      logic [15:0] e;
      case ($urandom_range(0, 4))
        0:       e = 16'h0000;
        1:       e = 16'h8000 | 16'($urandom);
        2:       e = 16'($urandom_range(0, 255));
        default: e = 16'($urandom);
      endcase
      strobe(16'($urandom), e, 1'($urandom));
      idle($urandom_range(0, 40));
    end
    idle(40);

    for (int k = 0; k < 200 && sbq.size() != 0; k++) @(negedge clk);
    check("drain_pending", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
